// File: rtl/mem_arbiter2_32_if.sv
// ============================================================================
// Module      : mem_arbiter2_32_if
// Description : Requester/memory bundle for the two-port 32-bit memory arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_arbiter2_32_if;
  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        ack0;
  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        ack1;
  logic [31:0] rdata;
  logic        sel;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_ack, mem_rdata,
    output ack0, ack1, rdata, sel, busy, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory model side
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_ack, mem_rdata,
    input  ack0, ack1, rdata, sel, busy, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter2_32.sv
// ============================================================================
// Module      : mem_arbiter2_32
// Description : Two-port arbiter sharing one 32-bit memory port (IDLE/BUSY/RESP).
//               Define ARB_ROUND_ROBIN_EN for round-robin ties; else port 0 wins.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter2_32 (
  input  wire logic           clk,
  input  wire logic           rst,
  mem_arbiter2_32_if.slave    io_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_sel;
  logic        r_busy;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        r_ack0;
  logic        r_ack1;
  logic        w_any_req;
  logic        w_grant;

  assign w_any_req = io_bus.req0 | io_bus.req1;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;
  // On a tie the port not served most recently wins.
  assign w_grant = (io_bus.req0 && io_bus.req1) ? ~r_last : io_bus.req1;
`else
  assign w_grant = ~io_bus.req0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_rdata     <= 32'd0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel       <= w_grant;
            r_mem_we    <= w_grant ? io_bus.we1    : io_bus.we0;
            r_mem_addr  <= w_grant ? io_bus.addr1  : io_bus.addr0;
            r_mem_wdata <= w_grant ? io_bus.wdata1 : io_bus.wdata0;
            r_mem_req   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Read data is captured on writes too; the requester just ignores it.
          if (io_bus.mem_ack) begin
            r_rdata   <= io_bus.mem_rdata;
            r_mem_req <= 1'b0;
            r_ack0    <= ~r_sel;
            r_ack1    <= r_sel;
`ifdef ARB_ROUND_ROBIN_EN
            r_last    <= r_sel;
`endif
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.sel       = r_sel;
  assign io_bus.busy      = r_busy;
  assign io_bus.mem_req   = r_mem_req;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.rdata     = r_rdata;
  assign io_bus.ack0      = r_ack0;
  assign io_bus.ack1      = r_ack1;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter2_32.sv
// ============================================================================
// Module      : tb_mem_arbiter2_32
// Description : Directed self-checking bench for mem_arbiter2_32 with a response scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter2_32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter2_32_if bus ();

  mem_arbiter2_32 dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    bit          port;
    logic [31:0] rdata;
  } resp_t;

  resp_t exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Bounded wait for the arbiter to raise mem_req.
  task automatic wait_memreq(input string tag);
    for (int i = 0; i < 8 && bus.mem_req !== 1'b1; i++) tick();
    chk(tag, {31'd0, bus.mem_req}, 32'd1);
  endtask

  // Called in the RESP cycle: compare the ack pulse and rdata against the scoreboard head.
  task automatic check_resp(input string tag);
    resp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_ack0"},    {31'd0, bus.ack0},    {31'd0, ~e.port});
      chk({tag, "_ack1"},    {31'd0, bus.ack1},    {31'd0, e.port});
      chk({tag, "_rdata"},   bus.rdata,            e.rdata);
      chk({tag, "_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
      chk({tag, "_busy"},    {31'd0, bus.busy},    32'd1);
    end
  endtask

  bit exp_grant[4];

  initial begin
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_sel",      {31'd0, bus.sel},     32'd0);
    chk("rst_busy",     {31'd0, bus.busy},    32'd0);
    chk("rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we",   {31'd0, bus.mem_we},  32'd0);
    chk("rst_mem_addr", bus.mem_addr,         32'd0);
    chk("rst_mem_wdat", bus.mem_wdata,        32'd0);
    chk("rst_rdata",    bus.rdata,            32'd0);
    chk("rst_acks",     {30'd0, bus.ack1, bus.ack0}, 32'd0);

    // Single read on port 0 with 2 wait cycles, plus address freeze during BUSY
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h40;
    exp_q.push_back('{port: 1'b0, rdata: 32'hDEADBEEF});
    tick();
    chk("rd_mem_req",  {31'd0, bus.mem_req}, 32'd1);
    chk("rd_sel",      {31'd0, bus.sel},     32'd0);
    chk("rd_mem_addr", bus.mem_addr,         32'h40);
    chk("rd_mem_we",   {31'd0, bus.mem_we},  32'd0);
    bus.addr0 = 32'h80;
    tick(); tick();
    chk("freeze_addr", bus.mem_addr, 32'h40);
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.mem_ack = 0; bus.req0 = 0;
    check_resp("rd");
    tick();
    chk("rd_idle_ack0", {31'd0, bus.ack0}, 32'd0);
    chk("rd_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Write on port 1 with zero-wait memory
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h100; bus.wdata1 = 32'h12345678;
    bus.mem_ack = 1; bus.mem_rdata = 32'hCAFEF00D;
    exp_q.push_back('{port: 1'b1, rdata: 32'hCAFEF00D});
    tick();
    chk("wr_sel",       {31'd0, bus.sel},    32'd1);
    chk("wr_mem_we",    {31'd0, bus.mem_we}, 32'd1);
    chk("wr_mem_addr",  bus.mem_addr,        32'h100);
    chk("wr_mem_wdata", bus.mem_wdata,       32'h12345678);
    chk("wr_no_early_ack", {31'd0, bus.ack1}, 32'd0);
    tick();
    bus.mem_ack = 0; bus.req1 = 0; bus.we1 = 0;
    check_resp("wr");
    tick();

    // Stray mem_ack in IDLE
    bus.mem_ack = 1; bus.mem_rdata = 32'h55555555;
    tick();
    bus.mem_ack = 0;
    chk("stray_busy",    {31'd0, bus.busy},    32'd0);
    chk("stray_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("stray_rdata",   bus.rdata,            32'hCAFEF00D);
    chk("stray_acks",    {30'd0, bus.ack1, bus.ack0}, 32'd0);
    tick();
    chk("stray_acks2",   {30'd0, bus.ack1, bus.ack0}, 32'd0);

    // Contention: both ports request continuously for 4 transactions
`ifdef ARB_ROUND_ROBIN_EN
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    bus.req0 = 1; bus.addr0 = 32'h200;
    bus.req1 = 1; bus.addr1 = 32'h300;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{port: exp_grant[i], rdata: 32'hA000_0000 + 32'(i)});
      wait_memreq($sformatf("ct%0d_wait", i));
      chk($sformatf("ct%0d_sel", i), {31'd0, bus.sel}, {31'd0, exp_grant[i]});
      chk($sformatf("ct%0d_addr", i), bus.mem_addr, exp_grant[i] ? 32'h300 : 32'h200);
      bus.mem_ack = 1; bus.mem_rdata = 32'hA000_0000 + 32'(i);
      tick();
      bus.mem_ack = 0;
      if (i == 3) begin
        bus.req0 = 0; bus.req1 = 0;
      end
      check_resp($sformatf("ct%0d", i));
      tick();
    end

    // Reset in BUSY abandons the transaction; next tie goes to port 0
    bus.req1 = 1; bus.addr1 = 32'h400;
    tick();
    chk("mr_sel_before", {31'd0, bus.sel}, 32'd1);
    bus.mem_ack = 1; bus.mem_rdata = 32'h77777777;
    rst = 1; bus.req1 = 0;
    tick();
    rst = 0; bus.mem_ack = 0;
    chk("mr_mem_req",  {31'd0, bus.mem_req}, 32'd0);
    chk("mr_sel",      {31'd0, bus.sel},     32'd0);
    chk("mr_busy",     {31'd0, bus.busy},    32'd0);
    chk("mr_mem_addr", bus.mem_addr,         32'd0);
    chk("mr_rdata",    bus.rdata,            32'd0);
    tick();
    chk("mr_no_ack",   {30'd0, bus.ack1, bus.ack0}, 32'd0);
    bus.req0 = 1; bus.addr0 = 32'h500;
    bus.req1 = 1; bus.addr1 = 32'h600;
    exp_q.push_back('{port: 1'b0, rdata: 32'h0BADF00D});
    tick();
    chk("mr_tie_sel",  {31'd0, bus.sel}, 32'd0);
    chk("mr_tie_addr", bus.mem_addr,     32'h500);
    bus.mem_ack = 1; bus.mem_rdata = 32'h0BADF00D;
    tick();
    bus.mem_ack = 0; bus.req0 = 0; bus.req1 = 0;
    check_resp("mr_tie");
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter2_32.md
# mem_arbiter2_32

Two-requester arbiter that shares one 32-bit memory port between an instruction-fetch master (port 0) and a data-access master (port 1). It owns the select line of the 32-bit 2:1 address/data multiplexers in front of the memory and sequences a request/acknowledge handshake on each side. It registers the winning request, drives the memory until it acknowledges, then returns read data and a one-cycle acknowledge to the winner.

## Interface
- No parameters; all data and address paths are fixed at 32 bits.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held high until ack0.
- we0  in  1  port 0 write enable (1 = write).
- addr0  in  32  port 0 byte address.
- wdata0  in  32  port 0 write data.
- ack0  out  1  one-cycle completion pulse to port 0.
- req1 / we1 / addr1 / wdata1 / ack1: same as port 0, for port 1.
- rdata  out  32  registered read data, valid in the ack cycle.
- sel  out  1  mux select: 0 = port 0 owns memory, 1 = port 1.
- busy  out  1  high while a transaction is outstanding.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  memory completion; may arrive in the first mem_req cycle.
- mem_rdata  in  32  memory read data, valid when mem_ack = 1.

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Any reqN high: pick a winner; set sel; capture the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata; go to BUSY.
- **BUSY**
  - mem_req = 1 and busy = 1.
  - Address, data and sel stay frozen; requester inputs are ignored.
  - On mem_ack: capture mem_rdata into rdata (also on writes); go to RESP.
- **RESP**
  - ackN = 1 for the winner only, mem_req = 0, busy = 1; go to IDLE.
- **Request rules**
  - A reqN still high in IDLE is treated as a new transaction.
  - Requesters must drop req in the cycle after ackN unless they are issuing back-to-back.
- **Arbitration**
  - A `last` pointer records the port served most recently.
  - When both ports request in IDLE, the port ≠ `last` wins.
  - A single requester always wins.
  - `last` updates on entry to RESP.
- **Other rules**
  - sel changes only on the IDLE→BUSY transition.
  - mem_ack outside BUSY is ignored.
  - A reqN that drops during BUSY does not abort the transaction; the ack is still issued.

## Timing
- Reset values: sel = 0, busy = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, ack0 = ack1 = 0, state = IDLE, `last` = 1 (port 0 wins the first tie).
- Request sampled at edge k → mem_req high in cycle k+1.
- mem_ack sampled at edge m → ackN and rdata valid in cycle m+1 → IDLE at edge m+2.
- Minimum of 3 cycles per transaction (zero-wait memory); next grant is possible at edge m+2.
- Reset asserted in any state: all outputs return to reset values at that edge; the in-flight transaction is abandoned with no ack.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin arbitration via `last`, as described above.
- Undefined: fixed priority, port 0 always wins ties; `last` is not implemented.
- State machine and handshake are identical in both builds.

## Test plan
- **Single read:** req0 = 1, addr0 = 0x00000040, mem_ack returned 2 cycles after mem_req with mem_rdata = 0xDEADBEEF → sel = 0, mem_addr = 0x40, ack0 pulses one cycle with rdata = 0xDEADBEEF; ack1 never asserts.
- **Write on port 1:** req1 = 1, we1 = 1, addr1 = 0x100, wdata1 = 0x12345678, zero-wait mem_ack → sel = 1, mem_we = 1, mem_wdata = 0x12345678; ack1 lands 2 cycles after the request is sampled.
- **Contention, round-robin build:** both ports request continuously for 4 transactions → grants go 0, 1, 0, 1. In the fixed-priority build → 0, 0, 0, 0.
- **Input freeze:** change addr0 from 0x40 to 0x80 during BUSY → mem_addr stays 0x40 until RESP.
- **Reset mid-operation:** assert rst in BUSY → next cycle mem_req = 0, sel = 0, no ack. A subsequent tie goes to port 0.
- **Stray ack:** pulse mem_ack while in IDLE → no state change, rdata unchanged, no ack.
